// File: rtl/fpu_wb_pkg.sv
// Shared types and constants for the FP writeback staging path.
package fpu_wb_pkg;

   // Completion tag; the destination-register field is 'rd' because 'reg' is reserved.
   typedef struct packed {
      logic [8:0]  rd;
      logic [9:0]  ii;
      logic [12:0] op;
   } fpu_wb_tag_t;

   localparam logic [3:0] FPU_WB_EN_ALT    = 4'b1001;
   localparam logic [8:0] FPU_WB_SREG_NONE = 9'h1ff;

endpackage

// File: rtl/fpu_tag_delay.sv
// LAT-stage valid+tag shift line aligning completion tags with their late result data.
module fpu_tag_delay
   import fpu_wb_pkg::*;
#(
   parameter int unsigned LAT = 5,
   localparam int unsigned IW = $clog2(LAT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   input  fpu_wb_tag_t   in_tag,
   output logic          out_valid,
   output fpu_wb_tag_t   out_tag,
   output logic [IW-1:0] inflight
);
   logic [LAT-1:0]              valid_q, valid_d;
   fpu_wb_tag_t [LAT-1:0]       tag_q, tag_d;

   // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
   always_comb begin
      valid_d[0] = in_valid && !flush;
      tag_d[0]   = in_tag;
      for (int i = 1; i < LAT; i++) begin
         valid_d[i] = valid_q[i-1] && !flush;
         tag_d[i]   = tag_q[i-1];
      end
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + IW'(valid_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign out_valid = valid_q[LAT-1];
   assign out_tag   = tag_q[LAT-1];

endmodule

// File: rtl/fpusqr_wb_queue.sv
// Writeback staging queue behind the FP sqrt/div alternate-result port.
// Define FPUSQR_WBQ_BYPASS_EN to load an empty queue's head straight from the pairing stage.
module fpusqr_wb_queue
   import fpu_wb_pkg::*;
#(
   parameter bit           H        = 1'b0,
   parameter int unsigned  DEPTH    = 4,
   parameter int unsigned  DATA_LAT = 5,
   localparam int unsigned DW       = (H ? 16 : 0) + 68
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          except,
   input  logic          alt_en,
   input  logic [8:0]    alt_reg,
   input  logic [9:0]    alt_II,
   input  logic [12:0]   alt_op,
   input  logic [DW-1:0] alt_data,
   output logic          pause,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [3:0]    wb_en,
   output logic [8:0]    wb_reg,
   output logic [9:0]    wb_II,
   output logic [12:0]   wb_op,
   output logic [DW-1:0] wb_data,
   output logic [8:0]    wb_sreg,
   output logic          ovf
);
   localparam int unsigned   PW   = $clog2(DEPTH);
   localparam int unsigned   CW   = PW + 1;
   localparam int unsigned   IW   = $clog2(DATA_LAT + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fpu_wb_tag_t   in_tag, tail_tag;
   logic          tail_valid, push, pop;
   logic [IW-1:0] inflight;
   int            inflight_d;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   fpu_wb_tag_t   mem_tag_q [DEPTH];
   fpu_wb_tag_t   mem_tag_d [DEPTH];
   logic [DW-1:0] mem_data_q [DEPTH];
   logic [DW-1:0] mem_data_d [DEPTH];
   logic          wb_valid_q, wb_valid_d, pause_q, pause_d, ovf_q, ovf_d;
   fpu_wb_tag_t   head_tag_q, head_tag_d;
   logic [DW-1:0] head_data_q, head_data_d;
`ifdef FPUSQR_WBQ_BYPASS_EN
   logic          byp_q, byp_d, byp_load;
`endif

   assign in_tag = '{rd: alt_reg, ii: alt_II, op: alt_op};

   fpu_tag_delay #(.LAT(DATA_LAT)) u_tag_delay (
      .clk       (clk),
      .rst       (rst),
      .flush     (except),
      .in_valid  (alt_en),
      .in_tag    (in_tag),
      .out_valid (tail_valid),
      .out_tag   (tail_tag),
      .inflight  (inflight)
   );

   assign pop  = wb_valid_q && wb_ready;
   assign push = tail_valid && !except;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      mem_tag_d  = mem_tag_q;
      mem_data_d = mem_data_q;
      ovf_d      = ovf_q;
`ifdef FPUSQR_WBQ_BYPASS_EN
      byp_d      = byp_q;
      byp_load   = 1'b0;
`endif
      // Pop is applied first so a push at full lands in the slot it frees.
      if (pop) begin
`ifdef FPUSQR_WBQ_BYPASS_EN
         if (!byp_q) rd_ptr_d = rd_ptr_q + PW'(1);
         byp_d = 1'b0;
`else
         rd_ptr_d = rd_ptr_q + PW'(1);
`endif
         count_d = count_q - CW'(1);
      end
      if (push) begin
         if (count_q == FULL && !pop) begin
            ovf_d = 1'b1;
`ifdef FPUSQR_WBQ_BYPASS_EN
         end else if (count_d == '0) begin
            byp_d    = 1'b1;
            byp_load = 1'b1;
            count_d  = count_d + CW'(1);
`endif
         end else begin
            mem_tag_d[wr_ptr_q]  = tail_tag;
            mem_data_d[wr_ptr_q] = alt_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
            count_d              = count_d + CW'(1);
         end
      end
      if (except) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
`ifdef FPUSQR_WBQ_BYPASS_EN
         byp_d    = 1'b0;
`endif
      end

      wb_valid_d  = (count_d != '0);
      head_tag_d  = '0;
      head_data_d = '0;
      if (wb_valid_d) begin
`ifdef FPUSQR_WBQ_BYPASS_EN
         if (byp_load) begin
            head_tag_d  = tail_tag;
            head_data_d = alt_data;
         end else if (byp_d) begin
            head_tag_d  = head_tag_q;
            head_data_d = head_data_q;
         end else
`endif
         begin
            head_tag_d  = mem_tag_d[rd_ptr_d];
            head_data_d = mem_data_d[rd_ptr_d];
         end
      end

      inflight_d = except ? 0 : int'(inflight) - int'(tail_valid) + int'(alt_en);
      pause_d    = (int'(count_d) + inflight_d) >= (int'(DEPTH) - 1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         wb_valid_q  <= 1'b0;
         pause_q     <= 1'b0;
         ovf_q       <= 1'b0;
         head_tag_q  <= '0;
         head_data_q <= '0;
`ifdef FPUSQR_WBQ_BYPASS_EN
         byp_q       <= 1'b0;
`endif
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         wb_valid_q  <= wb_valid_d;
         pause_q     <= pause_d;
         ovf_q       <= ovf_d;
         head_tag_q  <= head_tag_d;
         head_data_q <= head_data_d;
`ifdef FPUSQR_WBQ_BYPASS_EN
         byp_q       <= byp_d;
`endif
      end
   end

   // NOTE: the storage array has no reset; count and wb_valid gate every read, so stale words never escape.
   always_ff @(posedge clk) begin
      mem_tag_q  <= mem_tag_d;
      mem_data_q <= mem_data_d;
   end

   assign wb_valid = wb_valid_q;
   assign wb_en    = wb_valid_q ? FPU_WB_EN_ALT : 4'b0000;
   assign wb_reg   = head_tag_q.rd;
   assign wb_II    = head_tag_q.ii;
   assign wb_op    = head_tag_q.op;
   assign wb_data  = head_data_q;
   assign wb_sreg  = FPU_WB_SREG_NONE;
   assign pause    = pause_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_fpusqr_wb_queue.sv
// Directed bench for fpusqr_wb_queue (DEPTH=4, DATA_LAT=5, 68-bit data).
module tb_fpusqr_wb_queue;
   localparam int DW  = 68;
   localparam int LAT = 5;
   localparam logic [DW-1:0] JUNK = '1;

   localparam logic [8:0]    T_REG [8] = '{9'h012, 9'h0a1, 9'h155, 9'h1ff, 9'h001, 9'h100, 9'h0ff, 9'h033};
   localparam logic [9:0]    T_II  [8] = '{10'h055, 10'h101, 10'h2aa, 10'h3ff, 10'h001, 10'h200, 10'h1ff, 10'h044};
   localparam logic [12:0]   T_OP  [8] = '{13'h0001, 13'h1234, 13'h0f0f, 13'h1fff, 13'h0002, 13'h1000, 13'h0aaa, 13'h0555};
   localparam logic [DW-1:0] T_DAT [8] = '{68'h123, 68'hA_5555_0000_1111_2222, 68'h8_0000_0000_0000_0001,
                                           68'hF_FFFF_FFFF_FFFF_FFFE, 68'h7_7777_7777_7777_7777,
                                           68'h1_0203_0405_0607_0809, 68'h2_dead_beef_cafe_f00d,
                                           68'h3_0000_0000_ffff_0000};

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          except = 1'b0;
   logic          alt_en = 1'b0;
   logic [8:0]    alt_reg = '0;
   logic [9:0]    alt_II = '0;
   logic [12:0]   alt_op = '0;
   logic [DW-1:0] alt_data = JUNK;
   logic          wb_ready = 1'b0;
   logic          pause, wb_valid, ovf;
   logic [3:0]    wb_en;
   logic [8:0]    wb_reg, wb_sreg;
   logic [9:0]    wb_II;
   logic [12:0]   wb_op;
   logic [DW-1:0] wb_data;

   int checks = 0;
   int errors = 0;

   logic          dv [LAT];
   logic [DW-1:0] dd [LAT];
   logic [DW-1:0] pend_d = '0;

   always #5 clk = ~clk;

   fpusqr_wb_queue dut (
      .clk(clk), .rst(rst), .except(except),
      .alt_en(alt_en), .alt_reg(alt_reg), .alt_II(alt_II), .alt_op(alt_op), .alt_data(alt_data),
      .pause(pause), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en),
      .wb_reg(wb_reg), .wb_II(wb_II), .wb_op(wb_op), .wb_data(wb_data),
      .wb_sreg(wb_sreg), .ovf(ovf)
   );

   // Advance one clock; the upstream data pipe delivers each result DATA_LAT cycles after its alt_en.
   task automatic cycle();
      logic          v;
      logic [DW-1:0] d;
      v = alt_en;
      d = pend_d;
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
         dv[i] = dv[i-1];
         dd[i] = dd[i-1];
      end
      dv[0] = v;
      dd[0] = d;
      alt_data = dv[LAT-1] ? dd[LAT-1] : JUNK;
   endtask

   task automatic issue(input int idx);
      alt_en  = 1'b1;
      alt_reg = T_REG[idx];
      alt_II  = T_II[idx];
      alt_op  = T_OP[idx];
      pend_d  = T_DAT[idx];
      cycle();
      alt_en  = 1'b0;
      alt_reg = '0;
      alt_II  = '0;
      alt_op  = '0;
   endtask

   task automatic do_reset();
      alt_en   = 1'b0;
      except   = 1'b0;
      wb_ready = 1'b0;
      rst      = 1'b0;
      cycle();
      rst      = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cycle();
      cycle();
      checks++;
      if (wb_valid !== 1'b0 || wb_en !== 4'b0000) begin
         errors++;
         $display("FAIL reset_valid: got v=%b en=%b want v=0 en=0000", wb_valid, wb_en);
      end
      checks++;
      if (wb_reg !== '0 || wb_II !== '0 || wb_op !== '0 || wb_data !== '0) begin
         errors++;
         $display("FAIL reset_fields: got reg=%h II=%h op=%h data=%h want all 0", wb_reg, wb_II, wb_op, wb_data);
      end
      checks++;
      if (pause !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got pause=%b ovf=%b want 0 0", pause, ovf);
      end
      checks++;
      if (wb_sreg !== 9'h1ff) begin
         errors++;
         $display("FAIL reset_sreg: got %h want 1ff", wb_sreg);
      end
      rst = 1'b1;
   endtask

   task automatic test_single();
      wb_ready = 1'b1;
      issue(0);
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early[1]: wb_valid=%b want 0", wb_valid);
      end
      for (int k = 2; k <= LAT; k++) begin
         cycle();
         checks++;
         if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early[%0d]: wb_valid=%b want 0", k, wb_valid);
         end
      end
      cycle();
      checks++;
      if (wb_valid !== 1'b1 || wb_en !== 4'b1001 || wb_reg !== 9'h012 || wb_II !== 10'h055 ||
          wb_op !== 13'h0001 || wb_data !== 68'h123) begin
         errors++;
         $display("FAIL single_out: got v=%b en=%b reg=%h II=%h op=%h data=%h want v=1 en=1001 reg=012 II=055 op=0001 data=123",
                  wb_valid, wb_en, wb_reg, wb_II, wb_op, wb_data);
      end
      cycle();
      checks++;
      if (wb_valid !== 1'b0 || wb_en !== 4'b0000) begin
         errors++;
         $display("FAIL single_once: got v=%b en=%b want v=0 en=0000", wb_valid, wb_en);
      end
   endtask

   task automatic test_backpressure();
      int issued = 0;
      wb_ready = 1'b0;
      for (int a = 0; a < 4; a++) begin
         if (!pause) begin
            issue(1 + issued);
            issued++;
         end else begin
            cycle();
         end
      end
      checks++;
      if (issued != 3) begin
         errors++;
         $display("FAIL bp_issued: got %0d alt_en accepted want 3", issued);
      end
      for (int k = 0; k < LAT - 1; k++) begin
         checks++;
         if (pause !== 1'b1) begin
            errors++;
            $display("FAIL bp_pause[%0d]: pause=%b want 1", k, pause);
         end
         cycle();
      end
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_ovf: ovf=%b want 0", ovf);
      end
      wb_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         checks++;
         if (wb_valid !== 1'b1 || wb_reg !== T_REG[i] || wb_II !== T_II[i] || wb_op !== T_OP[i] || wb_data !== T_DAT[i]) begin
            errors++;
            $display("FAIL bp_drain[%0d]: got v=%b reg=%h II=%h op=%h data=%h want reg=%h II=%h op=%h data=%h",
                     i, wb_valid, wb_reg, wb_II, wb_op, wb_data, T_REG[i], T_II[i], T_OP[i], T_DAT[i]);
         end
         cycle();
      end
      checks++;
      if (wb_valid !== 1'b0 || pause !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got v=%b pause=%b ovf=%b want 0 0 0", wb_valid, pause, ovf);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 3; i <= 7; i++) issue(i);
      for (int k = 0; k < LAT - 1; k++) cycle();
      checks++;
      if (ovf !== 1'b0 || wb_valid !== 1'b1 || pause !== 1'b1 || wb_reg !== T_REG[3]) begin
         errors++;
         $display("FAIL ovf_full: got ovf=%b v=%b pause=%b reg=%h want 0 1 1 %h", ovf, wb_valid, pause, wb_reg, T_REG[3]);
      end
      cycle();
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: ovf=%b want 1", ovf);
      end
      checks++;
      if (wb_valid !== 1'b1 || wb_reg !== T_REG[3] || wb_II !== T_II[3] || wb_op !== T_OP[3] || wb_data !== T_DAT[3]) begin
         errors++;
         $display("FAIL ovf_head: got v=%b reg=%h II=%h op=%h data=%h want reg=%h II=%h op=%h data=%h",
                  wb_valid, wb_reg, wb_II, wb_op, wb_data, T_REG[3], T_II[3], T_OP[3], T_DAT[3]);
      end
      cycle();
      cycle();
      wb_ready = 1'b1;
      for (int i = 3; i <= 6; i++) begin
         checks++;
         if (wb_valid !== 1'b1 || wb_reg !== T_REG[i] || wb_II !== T_II[i] || wb_op !== T_OP[i] || wb_data !== T_DAT[i]) begin
            errors++;
            $display("FAIL ovf_drain[%0d]: got v=%b reg=%h II=%h op=%h data=%h want reg=%h II=%h op=%h data=%h",
                     i, wb_valid, wb_reg, wb_II, wb_op, wb_data, T_REG[i], T_II[i], T_OP[i], T_DAT[i]);
         end
         cycle();
      end
      checks++;
      if (wb_valid !== 1'b0 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got v=%b ovf=%b want v=0 ovf=1", wb_valid, ovf);
      end
   endtask

   task automatic test_push_pop_full();
      do_reset();
      for (int i = 0; i <= 4; i++) issue(i);
      for (int k = 0; k < LAT - 1; k++) cycle();
      checks++;
      if (wb_valid !== 1'b1 || wb_reg !== T_REG[0] || pause !== 1'b1) begin
         errors++;
         $display("FAIL pp_full: got v=%b reg=%h pause=%b want 1 %h 1", wb_valid, wb_reg, pause, T_REG[0]);
      end
      wb_ready = 1'b1;
      cycle();
      wb_ready = 1'b0;
      checks++;
      if (ovf !== 1'b0 || pause !== 1'b1 || wb_reg !== T_REG[1]) begin
         errors++;
         $display("FAIL pp_same: got ovf=%b pause=%b reg=%h want 0 1 %h", ovf, pause, wb_reg, T_REG[1]);
      end
      wb_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (wb_valid !== 1'b1 || wb_reg !== T_REG[i] || wb_II !== T_II[i] || wb_op !== T_OP[i] || wb_data !== T_DAT[i]) begin
            errors++;
            $display("FAIL pp_drain[%0d]: got v=%b reg=%h II=%h op=%h data=%h want reg=%h II=%h op=%h data=%h",
                     i, wb_valid, wb_reg, wb_II, wb_op, wb_data, T_REG[i], T_II[i], T_OP[i], T_DAT[i]);
         end
         cycle();
      end
      checks++;
      if (wb_valid !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL pp_end: got v=%b ovf=%b want 0 0", wb_valid, ovf);
      end
   endtask

   task automatic test_flush();
      int seen = 0;
      do_reset();
      issue(0);
      issue(1);
      cycle();
      cycle();
      issue(2);
      issue(3);
      cycle();
      checks++;
      if (wb_valid !== 1'b1 || wb_reg !== T_REG[0]) begin
         errors++;
         $display("FAIL flush_pre: got v=%b reg=%h want 1 %h", wb_valid, wb_reg, T_REG[0]);
      end
      except = 1'b1;
      issue(4);
      except = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || pause !== 1'b0) begin
         errors++;
         $display("FAIL flush_next: got v=%b pause=%b want 0 0", wb_valid, pause);
      end
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (wb_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL flush_stale: got %0d valid cycles want 0", seen);
      end
      checks++;
      if (pause !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL flush_flags: got pause=%b ovf=%b want 0 0", pause, ovf);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      do_reset();
      issue(5);
      issue(6);
      for (int k = 0; k < LAT - 1; k++) cycle();
      checks++;
      if (wb_valid !== 1'b1 || wb_reg !== T_REG[5]) begin
         errors++;
         $display("FAIL rmid_pre: got v=%b reg=%h want 1 %h", wb_valid, wb_reg, T_REG[5]);
      end
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      checks++;
      if (wb_valid !== 1'b0 || wb_en !== 4'b0000 || wb_reg !== '0 || wb_II !== '0 || wb_op !== '0 ||
          wb_data !== '0 || pause !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL rmid_zero: got v=%b en=%b reg=%h II=%h op=%h data=%h pause=%b ovf=%b want all 0",
                  wb_valid, wb_en, wb_reg, wb_II, wb_op, wb_data, pause, ovf);
      end
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (wb_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rmid_stale: got %0d valid cycles want 0", seen);
      end
      wb_ready = 1'b1;
      issue(7);
      for (int k = 1; k < LAT; k++) cycle();
      cycle();
      checks++;
      if (wb_valid !== 1'b1 || wb_reg !== T_REG[7] || wb_II !== T_II[7] || wb_op !== T_OP[7] || wb_data !== T_DAT[7]) begin
         errors++;
         $display("FAIL rmid_resume: got v=%b reg=%h II=%h op=%h data=%h want reg=%h II=%h op=%h data=%h",
                  wb_valid, wb_reg, wb_II, wb_op, wb_data, T_REG[7], T_II[7], T_OP[7], T_DAT[7]);
      end
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) begin
         dv[i] = 1'b0;
         dd[i] = JUNK;
      end
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_push_pop_full();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
